// File: rtl/skid_buf_fully_registered.sv
// Two-entry skid buffer with every output driven straight from a flop.
// Define SKID_STALL_CNT_EN to add the saturating stall_cnt_o counter.
module skid_buf_fully_registered #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_srdy_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_rrdy_o,
    input  logic              out_rrdy_i,
    output logic              out_srdy_o,
`ifdef SKID_STALL_CNT_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic [DATA_W-1:0] out_data_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_rrdy_q, in_rrdy_d;
    logic              out_srdy_q, out_srdy_d;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_srdy_i & in_rrdy_q;
    assign out_xfer = out_srdy_q & out_rrdy_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_rrdy_q  <= 1'b1;
            out_srdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_rrdy_q  <= in_rrdy_d;
            out_srdy_q <= out_srdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data_i;
                end else if (in_xfer) begin
                    skid_d  = in_data_i;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flag flops are loaded from the next state so they track state_q.
        in_rrdy_d  = (state_d != FULL);
        out_srdy_d = (state_d != EMPTY);
    end

    assign in_rrdy_o  = in_rrdy_q;
    assign out_srdy_o = out_srdy_q;
    assign out_data_o = main_q;

`ifdef SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_srdy_q && !out_rrdy_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
